fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage.
- Decides every cycle whether the PC advances, holds or redirects, and whether the IF/ID register loads, holds or is flushed.
- Arbitrates simultaneous redirect requests (JR, J, Z) and supports a multi-cycle instruction memory through an imem_req/imem_ready handshake.
- Latches a redirect that arrives while memory is busy and detects fetch timeouts.

Parameters:
- TIMEOUT, 16: consecutive not-ready cycles before fetch_err is raised.
- CNT_W, 16: width of the stall_cycles performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Z  input  1  branch taken, resolved this cycle.
- J  input  1  jump.
- JR  input  1  jump-register.
- BranchAddr  input  32  branch target.
- JumpAddr  input  32  jump target.
- JrAddr  input  32  register target.
- LoadUse  input  1  load-use hazard from decode; requests hold.
- imem_ready  input  1  instruction memory returns a valid word this cycle.
- imem_req  output  1  fetch request to instruction memory.
- PC_IFWrite  output  1  PC register load enable.
- PCSel  output  1  0 = sequential PC+4, 1 = Target_pc.
- Target_pc  output  32  redirect target.
- IFID_Write  output  1  IF/ID load enable.
- IFID_Flush  output  1  load NOP into IF/ID (takes precedence over IFID_Write).
- fetch_err  output  1  sticky fetch timeout flag.
- stall_cycles  output  CNT_W  saturating count of cycles in which the PC did not advance.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low, and applies to all state.
- Reset values:
  - state = IDLE, pend_addr = 0, wait_cnt = 0, stall_cycles = 0, fetch_err = 0.
  - Outputs while in reset: imem_req = 0, PC_IFWrite = 0, IFID_Write = 0, IFID_Flush = 1, PCSel = 0, Target_pc = 0.
- Output timing: control outputs are combinational from (state, inputs), i.e. zero-cycle latency from request to control. Counters and pend_addr are registered.
- Redirect priority: JR > J > Z. redir = JR|J|Z. live_tgt = JrAddr, else JumpAddr, else BranchAddr.
- IDLE: all enables 0, IFID_Flush = 1. Next state is FETCH unconditionally.
- FETCH: imem_req = 1.
  - imem_ready & redir: PC_IFWrite = 1, PCSel = 1, Target_pc = live_tgt, IFID_Flush = 1. Stay in FETCH.
  - imem_ready & !redir & LoadUse: PC_IFWrite = 0, IFID_Write = 0 (hold both).
  - imem_ready & neither: PC_IFWrite = 1, PCSel = 0, IFID_Write = 1.
  - !imem_ready & redir: pend_addr <= live_tgt; go to WAIT_REDIR; PC_IFWrite = 0; IFID_Flush = 1.
  - !imem_ready & !redir: PC_IFWrite = 0. IFID_Write = 0 if LoadUse, else IFID_Flush = 1 (bubble).
- WAIT_REDIR: imem_req = 1. Redirect inputs are ignored; the first redirect wins because younger ones are wrong-path. Target_pc = pend_addr.
  - On imem_ready: the returned word is discarded (IFID_Flush = 1), PC_IFWrite = 1, PCSel = 1; go to FETCH.
  - Otherwise PC_IFWrite = 0 and IFID_Flush = 1.
- Redirect vs. LoadUse in the same cycle: the redirect wins (the branch is older). LoadUse is ignored.
- Timeout:
  - wait_cnt increments on every imem_req & !imem_ready cycle and clears on imem_ready.
  - When wait_cnt reaches TIMEOUT-1 and imem_ready is still low, go to ERROR.
- ERROR:
  - imem_req = 0, PC_IFWrite = 0, IFID_Write = 0, IFID_Flush = 1, fetch_err = 1.
  - No exit except reset.
- stall_cycles: increments in FETCH/WAIT_REDIR whenever PC_IFWrite = 0. Saturates at 2^CNT_W-1. Frozen in IDLE/ERROR.
- Reset asserted mid-wait: pend_addr and wait_cnt are lost; the controller restarts via IDLE with no redirect replayed.
- Target_pc when no redirect is active: 0 in FETCH, pend_addr in WAIT_REDIR.

Decomposition:
- Shared package:
  - state enum IDLE / FETCH / WAIT_REDIR / ERROR.
  - PCSel constants PCSEL_SEQ = 0, PCSEL_TGT = 1.
  - default TIMEOUT.
- One natural sub-module: redirect_prio, the combinational JR>J>Z priority mux producing redir and live_tgt.

Test Plan:
- Reset released with imem_ready = 1 for 3 cycles: cycle 0 in IDLE (Flush = 1, req = 0), then PC_IFWrite = 1, PCSel = 0, IFID_Write = 1 each cycle; stall_cycles = 0.
- JR = 1, J = 1, Z = 1 with JrAddr = 0x40, JumpAddr = 0x80, BranchAddr = 0xC0 and ready = 1 -> Target_pc = 0x40, PCSel = 1, IFID_Flush = 1.
- LoadUse = 1 for 2 cycles with ready = 1 -> PC_IFWrite = 0, IFID_Write = 0, IFID_Flush = 0; stall_cycles = 2. LoadUse together with Z = 1 -> redirect taken.
- imem_ready = 0 for 3 cycles with J = 1 (JumpAddr = 0x100) in the first of them, then ready = 1 -> Flush = 1 on all 4 cycles; PC_IFWrite = 1, Target_pc = 0x100 on the ready cycle; a Z pulse during the wait is ignored.
- imem_ready held 0 for TIMEOUT = 16 cycles -> fetch_err = 1 and imem_req = 0 from the next cycle; stays set until reset, which clears it.
- Reset asserted during WAIT_REDIR -> all outputs take their reset values immediately (async); after release, sequential fetch with PCSel = 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FETCH      = 2'd1,
      WAIT_REDIR = 2'd2,
      ERROR      = 2'd3
   } state_e;

   localparam logic PCSEL_SEQ = 1'b0;
   localparam logic PCSEL_TGT = 1'b1;

   localparam int TIMEOUT_DEFAULT = 16;
   localparam int CNT_W_DEFAULT   = 16;

endpackage

// File: rtl/fetch_ctrl_redirect_prio.sv
// Combinational redirect arbiter: jump-register beats jump, jump beats branch.
module fetch_ctrl_redirect_prio
   import fetch_ctrl_pkg::*;
(
   input  logic        jr,
   input  logic        j,
   input  logic        z,
   input  logic [31:0] jr_addr,
   input  logic [31:0] jump_addr,
   input  logic [31:0] branch_addr,
   output logic        redir,
   output logic [31:0] live_tgt
);

   always_comb begin
      redir    = jr | j | z;
      live_tgt = branch_addr;
      if (jr) begin
         live_tgt = jr_addr;
      end else if (j) begin
         live_tgt = jump_addr;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC advance/hold/redirect, IF/ID load/hold/flush,
// multi-cycle imem handshake with pending-redirect capture and timeout.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Z,
   input  logic             J,
   input  logic             JR,
   input  logic [31:0]      BranchAddr,
   input  logic [31:0]      JumpAddr,
   input  logic [31:0]      JrAddr,
   input  logic             LoadUse,
   input  logic             imem_ready,
   output logic             imem_req,
   output logic             PC_IFWrite,
   output logic             PCSel,
   output logic [31:0]      Target_pc,
   output logic             IFID_Write,
   output logic             IFID_Flush,
   output logic             fetch_err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              fetch_err_q, fetch_err_d;

   logic              redir;
   logic [31:0]       live_tgt;

   fetch_ctrl_redirect_prio u_prio (
      .jr          (JR),
      .j           (J),
      .z           (Z),
      .jr_addr     (JrAddr),
      .jump_addr   (JumpAddr),
      .branch_addr (BranchAddr),
      .redir       (redir),
      .live_tgt    (live_tgt)
   );

   always_comb begin
      state_d     = state_q;
      pend_addr_d = pend_addr_q;
      wait_cnt_d  = wait_cnt_q;
      imem_req    = 1'b0;
      PC_IFWrite  = 1'b0;
      PCSel       = PCSEL_SEQ;
      Target_pc   = '0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b0;

      case (state_q)
         IDLE: begin
            IFID_Flush = 1'b1;
            wait_cnt_d = '0;
            state_d    = FETCH;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               // A redirect outranks LoadUse because the branch is the older instruction.
               if (redir) begin
                  PC_IFWrite = 1'b1;
                  PCSel      = PCSEL_TGT;
                  Target_pc  = live_tgt;
                  IFID_Flush = 1'b1;
               end else if (!LoadUse) begin
                  PC_IFWrite = 1'b1;
                  IFID_Write = 1'b1;
               end
            end else if (redir) begin
               pend_addr_d = live_tgt;
               IFID_Flush  = 1'b1;
               state_d     = WAIT_REDIR;
            end else if (!LoadUse) begin
               IFID_Flush = 1'b1;
            end
         end
         WAIT_REDIR: begin
            imem_req   = 1'b1;
            Target_pc  = pend_addr_q;
            IFID_Flush = 1'b1;
            if (imem_ready) begin
               PC_IFWrite = 1'b1;
               PCSel      = PCSEL_TGT;
               state_d    = FETCH;
            end
         end
         default: begin
            IFID_Flush = 1'b1;
         end
      endcase

      // Timeout overrides any other transition once memory has been silent too long.
      if (imem_req) begin
         if (imem_ready) begin
            wait_cnt_d = '0;
         end else if (wait_cnt_q == WAIT_LAST) begin
            state_d = ERROR;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if ((state_q == FETCH || state_q == WAIT_REDIR) && !PC_IFWrite && (stall_q != '1)) begin
         stall_d = stall_q + 1'b1;
      end
      fetch_err_d = fetch_err_q | (state_d == ERROR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         pend_addr_q <= '0;
         wait_cnt_q  <= '0;
         stall_q     <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_addr_q <= pend_addr_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_q     <= stall_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign fetch_err    = fetch_err_q;
   assign stall_cycles = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scenario-driven bench for fetch_ctrl with an expected-control scoreboard.
module tb_fetch_ctrl;

   typedef struct packed {
      logic        req;
      logic        pcw;
      logic        pcsel;
      logic        ifw;
      logic        flush;
      logic        err;
      logic [31:0] tgt;
   } ctl_t;

   logic        clk;
   logic        reset;
   logic        Z, J, JR, LoadUse, imem_ready;
   logic [31:0] BranchAddr, JumpAddr, JrAddr;
   logic        imem_req, PC_IFWrite, PCSel, IFID_Write, IFID_Flush, fetch_err;
   logic [31:0] Target_pc;
   logic [15:0] stall_cycles;

   int   total;
   int   bad;
   ctl_t sb[$];
   ctl_t got, want;

   fetch_ctrl #(.TIMEOUT(16), .CNT_W(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .Z            (Z),
      .J            (J),
      .JR           (JR),
      .BranchAddr   (BranchAddr),
      .JumpAddr     (JumpAddr),
      .JrAddr       (JrAddr),
      .LoadUse      (LoadUse),
      .imem_ready   (imem_ready),
      .imem_req     (imem_req),
      .PC_IFWrite   (PC_IFWrite),
      .PCSel        (PCSel),
      .Target_pc    (Target_pc),
      .IFID_Write   (IFID_Write),
      .IFID_Flush   (IFID_Flush),
      .fetch_err    (fetch_err),
      .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ctl_t mk(input logic req, pcw, pcsel, ifw, flush, err, input logic [31:0] tgt);
      ctl_t c;
      c = '{req: req, pcw: pcw, pcsel: pcsel, ifw: ifw, flush: flush, err: err, tgt: tgt};
      return c;
   endfunction

   function automatic ctl_t sample();
      return mk(imem_req, PC_IFWrite, PCSel, IFID_Write, IFID_Flush, fetch_err, Target_pc);
   endfunction

   // Drive one cycle of stimulus mid-period and queue the control word it must produce.
   task automatic drive(input logic rn, jr, j, z, lu, rdy,
                        input logic [31:0] jra, ja, ba, input ctl_t e);
      @(negedge clk);
      reset      = rn;
      JR         = jr;
      J          = j;
      Z          = z;
      LoadUse    = lu;
      imem_ready = rdy;
      JrAddr     = jra;
      JumpAddr   = ja;
      BranchAddr = ba;
      sb.push_back(e);
      #1;
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset_outputs: got=%h want=%h", got, want); end
      total++;
      if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall: got=%0d want=0", stall_cycles); end
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL release_idle: got=%h want=%h", got, want); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0));
         got = sample(); want = sb.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL seq_fetch[%0d]: got=%h want=%h", i, got, want); end
      end
      @(posedge clk); #1;
      total++;
      if (stall_cycles !== 16'd0) begin bad++; $display("FAIL seq_stall: got=%0d want=0", stall_cycles); end
   endtask

   task automatic test_priority();
      logic [2:0]  req_tab [3];
      logic [31:0] tgt_tab [3];
      req_tab = '{3'b111, 3'b011, 3'b001};
      tgt_tab = '{32'h40, 32'h80, 32'hC0};
      for (int i = 0; i < 3; i++) begin
         drive(1, req_tab[i][2], req_tab[i][1], req_tab[i][0], 0, 1, 32'h40, 32'h80, 32'hC0,
               mk(1, 1, 1, 0, 1, 0, tgt_tab[i]));
         got = sample(); want = sb.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL prio[%0d]: got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 1, 1, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0));
         got = sample(); want = sb.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL loaduse_hold[%0d]: got=%h want=%h", i, got, want); end
      end
      @(posedge clk); #1;
      total++;
      if (stall_cycles !== 16'd2) begin bad++; $display("FAIL loaduse_stall: got=%0d want=2", stall_cycles); end
      drive(1, 0, 0, 1, 1, 1, 0, 0, 32'h200, mk(1, 1, 1, 0, 1, 0, 32'h200));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL loaduse_vs_branch: got=%h want=%h", got, want); end
   endtask

   task automatic test_wait_redir();
      drive(1, 0, 1, 0, 0, 0, 0, 32'h100, 0, mk(1, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_capture: got=%h want=%h", got, want); end
      drive(1, 0, 0, 1, 0, 0, 0, 0, 32'h300, mk(1, 0, 0, 0, 1, 0, 32'h100));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_ignore_z: got=%h want=%h", got, want); end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 32'h100));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_hold: got=%h want=%h", got, want); end
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(1, 1, 1, 0, 1, 0, 32'h100));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_release: got=%h want=%h", got, want); end
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL wait_resume_seq: got=%h want=%h", got, want); end
      @(posedge clk); #1;
      total++;
      if (stall_cycles !== 16'd5) begin bad++; $display("FAIL wait_stall: got=%0d want=5", stall_cycles); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 16; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 0));
         got = sample(); want = sb.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL timeout_wait[%0d]: got=%h want=%h", i, got, want); end
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 1, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL timeout_error: got=%h want=%h", got, want); end
      drive(1, 0, 1, 0, 0, 1, 0, 32'h700, 0, mk(0, 0, 0, 0, 1, 1, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL error_sticky: got=%h want=%h", got, want); end
      @(posedge clk); #1;
      total++;
      if (stall_cycles !== 16'd21) begin bad++; $display("FAIL error_stall_frozen: got=%0d want=21", stall_cycles); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL error_reset_clear: got=%h want=%h", got, want); end
   endtask

   task automatic test_reset_mid_wait();
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_idle: got=%h want=%h", got, want); end
      drive(1, 1, 0, 0, 0, 0, 32'h500, 0, 0, mk(1, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_capture: got=%h want=%h", got, want); end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 1, 0, 32'h500));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_waiting: got=%h want=%h", got, want); end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_async_reset: got=%h want=%h", got, want); end
      total++;
      if (stall_cycles !== 16'd0) begin bad++; $display("FAIL mid_reset_stall: got=%0d want=0", stall_cycles); end
      drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 1, 0, 0));
      got = sample(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mid_restart_idle: got=%h want=%h", got, want); end
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 0, 0, mk(1, 1, 0, 1, 0, 0, 0));
         got = sample(); want = sb.pop_front(); total++;
         if (got !== want) begin bad++; $display("FAIL mid_restart_seq[%0d]: got=%h want=%h", i, got, want); end
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b0;
      Z          = 1'b0;
      J          = 1'b0;
      JR         = 1'b0;
      LoadUse    = 1'b0;
      imem_ready = 1'b0;
      BranchAddr = '0;
      JumpAddr   = '0;
      JrAddr     = '0;
      test_reset();
      test_priority();
      test_load_use();
      test_wait_redir();
      test_timeout();
      test_reset_mid_wait();
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain: got=%0d want=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
